// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with 2-bit saturating counters and a tagged BTB.
// Lookup is combinational from registered state; updates from execute land on the clock edge.
module branch_predictor_bht #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       lookup_pc,
  output logic              predict_hit,
  output logic              predict_taken,
  output logic [31:0]       predict_target,
  input  logic              update_valid,
  input  logic [31:0]       update_pc,
  input  logic              update_taken,
  input  logic [31:0]       update_target,
  input  logic              update_mispredict,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int unsigned Depth = 2 ** IDX_BITS;
  localparam int unsigned TagW  = 30 - IDX_BITS;

  logic [Depth-1:0] valid_q, valid_d;
  logic [TagW-1:0]  tag_q    [Depth];
  logic [TagW-1:0]  tag_d    [Depth];
  logic [31:0]      target_q [Depth];
  logic [31:0]      target_d [Depth];
  logic [1:0]       ctr_q    [Depth];
  logic [1:0]       ctr_d    [Depth];

  logic [STAT_W-1:0] branch_q, branch_d;
  logic [STAT_W-1:0] mispred_q, mispred_d;

  logic [IDX_BITS-1:0] lkp_idx, upd_idx;
  logic [TagW-1:0]     lkp_tag, upd_tag;
  logic                upd_hit;
  logic [1:0]          unused_upd_pc_bits;

  assign lkp_idx            = lookup_pc[IDX_BITS+1:2];
  assign lkp_tag            = lookup_pc[31:IDX_BITS+2];
  assign upd_idx            = update_pc[IDX_BITS+1:2];
  assign upd_tag            = update_pc[31:IDX_BITS+2];
  assign unused_upd_pc_bits = update_pc[1:0];
  assign upd_hit            = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup sees only registered state, so a same-cycle update is not bypassed.
  always_comb begin
    predict_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    predict_taken  = predict_hit && ctr_q[lkp_idx][1];
    predict_target = predict_taken ? target_q[lkp_idx] : (lookup_pc + 32'd4);
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (update_valid) begin
      if (upd_hit) begin
        if (update_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = update_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (update_taken) begin
        // Taken miss evicts whatever alias occupies the slot.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = update_target;
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  always_comb begin
    branch_d  = branch_q;
    mispred_d = mispred_q;
    if (update_valid && (branch_q != {STAT_W{1'b1}})) branch_d = branch_q + 1'b1;
    if (update_valid && update_mispredict && (mispred_q != {STAT_W{1'b1}})) begin
      mispred_d = mispred_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      branch_q  <= '0;
      mispred_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q   <= valid_d;
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
      for (int i = 0; i < Depth; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

  assign branch_count     = branch_q;
  assign mispredict_count = mispred_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed scenarios plus random traffic
// compared against an abstract table model.
module tb_branch_predictor_bht;

  localparam int unsigned StatMax = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        predict_hit, predict_taken;
  logic [31:0] predict_target;
  logic        update_valid, update_taken, update_mispredict;
  logic [31:0] update_pc, update_target;
  logic [3:0]  branch_count, mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: entry state kept as plain integers indexed by PC word slot.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_bc, m_mc;

  branch_predictor_bht #(.IDX_BITS(4), .STAT_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .lookup_pc        (lookup_pc),
    .predict_hit      (predict_hit),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .update_mispredict(update_mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                              input logic mp);
    int unsigned slot = (pc / 4) % 16;
    int unsigned tg   = pc / 64;
    if (m_bc < StatMax) m_bc++;
    if (mp && m_mc < StatMax) m_mc++;
    if (m_valid[slot] && m_tag[slot] == tg) begin
      if (tk) begin
        m_ctr[slot] = (m_ctr[slot] + 1 > 3) ? 3 : m_ctr[slot] + 1;
        m_tgt[slot] = tgt;
      end else begin
        m_ctr[slot] = (m_ctr[slot] - 1 < 0) ? 0 : m_ctr[slot] - 1;
      end
    end else if (tk) begin
      m_valid[slot] = 1'b1;
      m_tag[slot]   = tg;
      m_tgt[slot]   = tgt;
      m_ctr[slot]   = 2;
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned slot = (lookup_pc / 4) % 16;
    bit          hit  = m_valid[slot] && (m_tag[slot] == lookup_pc / 64);
    bit          tk   = hit && (m_ctr[slot] >= 2);
    logic [31:0] tgt  = tk ? m_tgt[slot] : lookup_pc + 32'd4;
    chk({tag, "_hit"}, {31'b0, predict_hit}, {31'b0, hit});
    chk({tag, "_taken"}, {31'b0, predict_taken}, {31'b0, tk});
    chk({tag, "_target"}, predict_target, tgt);
    chk({tag, "_bcnt"}, {28'b0, branch_count}, m_bc);
    chk({tag, "_mcnt"}, {28'b0, mispredict_count}, m_mc);
  endtask

  // Called at posedge+1; drives one cycle, checks before the next edge, then updates model.
  task automatic cycle(input string tag, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic um);
    lookup_pc         = lpc;
    update_valid      = uv;
    update_pc         = upc;
    update_taken      = ut;
    update_target     = utgt;
    update_mispredict = um;
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    if (reset && uv) model_update(upc, ut, utgt, um);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    update_valid = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    #1 check_outputs(tag);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset             = 1'b0;
    lookup_pc         = 32'h10;
    update_valid      = 1'b0;
    update_pc         = 32'h0;
    update_taken      = 1'b0;
    update_target     = 32'h0;
    update_mispredict = 1'b0;
    model_reset();

    // Reset state
    #3 chk("rst_hit", {31'b0, predict_hit}, 32'h0);
    chk("rst_target", predict_target, 32'h14);
    chk("rst_bcnt", {28'b0, branch_count}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    cycle("t1", 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Allocate, then lookup sees it from the following cycle
    cycle("t2a", 32'h10, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0);
    chk("t2_target_lit", predict_target, 32'h40);
    cycle("t2b", 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Counter walks down and saturates, then back up
    for (int i = 0; i < 3; i++) cycle("t3nt", 32'h10, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
    cycle("t3low", 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) cycle("t3t", 32'h10, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0);
    chk("t3_taken_lit", {31'b0, predict_taken}, 32'h1);
    cycle("t3up", 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Aliasing on the same slot
    cycle("t4a", 32'h50, 1'b1, 32'h50, 1'b0, 32'h0, 1'b0);
    cycle("t4b", 32'h10, 1'b1, 32'h50, 1'b1, 32'h80, 1'b0);
    chk("t4_oldhit_lit", {31'b0, predict_hit}, 32'h0);
    cycle("t4c", 32'h50, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Same-cycle lookup and update: no bypass (ctr driven to 01 first)
    pulse_reset("t5rst");
    cycle("t5a", 32'h10, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0);
    cycle("t5b", 32'h10, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    cycle("t5c", 32'h10, 1'b1, 32'h10, 1'b1, 32'h44, 1'b0);
    cycle("t5d", 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Fall-through wraps at the top of the address space
    cycle("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wrap_lit", predict_target, 32'h0);

    // Random traffic over a few tags per slot to force aliasing
    for (int i = 0; i < 400; i++) begin
      logic [31:0] lpc, upc;
      if (i % 60 == 59) pulse_reset("rnd_rst");
      lpc = {$urandom_range(3, 0) * 32'h40} | ($urandom_range(15, 0) << 2);
      upc = {$urandom_range(3, 0) * 32'h40} | ($urandom_range(15, 0) << 2);
      if (i % 97 == 5) lpc = 32'hFFFF_FFFC;
      cycle("rnd", lpc, 1'($urandom_range(1, 0)), upc, 1'($urandom_range(1, 0)),
            $urandom & 32'hFFFF_FFFC, 1'($urandom_range(1, 0)));
    end

    // Saturating stats, then asynchronous reset mid-run
    pulse_reset("t6rst");
    for (int i = 0; i < 20; i++) begin
      cycle("t6", 32'h10, 1'b1, 32'h10 + 32'(i % 4) * 4, 1'b1, 32'h100 + 32'(i), 1'b1);
    end
    cycle("t6sat", 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("t6_bcnt_lit", {28'b0, branch_count}, 32'hF);
    chk("t6_mcnt_lit", {28'b0, mispredict_count}, 32'hF);
    #2 reset = 1'b0;
    model_reset();
    #1 chk("t6_async_bcnt", {28'b0, branch_count}, 32'h0);
    chk("t6_async_mcnt", {28'b0, mispredict_count}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'h10 + 32'(i) * 4;
      #1 chk("t6_clear_hit", {31'b0, predict_hit}, 32'h0);
    end
    @(posedge clk);
    #1;
    // Updates while reset is held must be dropped
    cycle("t6held", 32'h10, 1'b1, 32'h10, 1'b1, 32'h200, 1'b1);
    update_valid = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    cycle("t6post", 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
